// File: rtl/mac_sequence_ctrl_pkg.sv
// rtl/mac_sequence_ctrl_pkg.sv - shared states and latency constants for the MAC sequencer
package mac_sequence_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int MEM_LAT_DEF = 1;
  localparam int DSP_LAT_DEF = 3;
  localparam int TOTAL_LAT   = MEM_LAT_DEF + DSP_LAT_DEF;

  function automatic int total_lat(input int mem_lat, input int dsp_lat);
    return mem_lat + dsp_lat;
  endfunction

endpackage

// File: rtl/mac_sequence_ctrl_latency_timer.sv
// rtl/mac_sequence_ctrl_latency_timer.sv - loadable down-counter with zero flag
module mac_sequence_ctrl_latency_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Holds at zero once expired so the owner decides when to reload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mac_sequence_ctrl.sv
// rtl/mac_sequence_ctrl.sv - address walker and result capture for the BRAM-fed A*B+C datapath
module mac_sequence_ctrl
  import mac_sequence_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int DEPTH   = 8,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int DSP_LAT = DSP_LAT_DEF,
  parameter int P_W     = 37
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode_cont,
  input  logic              step_en,
  input  logic [P_W-1:0]    p_in,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [P_W-1:0]    result,
  output logic [ADDR_W-1:0] result_addr,
  output logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int                LAT       = total_lat(MEM_LAT, DSP_LAT);
  localparam int                CNT_W     = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0]  LOAD_VAL  = CNT_W'(LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [P_W-1:0]      result_q;
  logic [ADDR_W-1:0]   result_addr_q;
  logic                result_valid_q;
  logic                done_q;
  logic                overrun_q;
  logic                timer_load;
  logic                timer_zero;

  assign timer_load = !abort && (state_q == ST_ARMED) && step_en;

  mac_sequence_ctrl_latency_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clock_100Mhz),
    .rst_ni     (reset),
    .load_i     (timer_load),
    .load_val_i (LOAD_VAL),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      mem_addr_q     <= '0;
      result_q       <= '0;
      result_addr_q  <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      if (abort) begin
        state_q    <= ST_IDLE;
        mem_addr_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q    <= ST_ARMED;
              mem_addr_q <= '0;
              overrun_q  <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (step_en) state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            // A pace tick arriving mid-flight is lost; flag it for the operator.
            if (step_en) overrun_q <= 1'b1;
            if (timer_zero) begin
              result_q       <= p_in;
              result_addr_q  <= mem_addr_q;
              result_valid_q <= 1'b1;
              if (mem_addr_q == LAST_ADDR) begin
                mem_addr_q <= '0;
                if (mode_cont) begin
                  state_q <= ST_ARMED;
                end else begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
                end
              end else begin
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
                state_q    <= ST_ARMED;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign mem_en       = busy;
  assign mem_addr     = mem_addr_q;
  assign result       = result_q;
  assign result_addr  = result_addr_q;
  assign result_valid = result_valid_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule
